mem_port_arbiter: RTL and testbench

Arbiter sharing one single-port, pipelined memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage RISC-V pipeline. It grants at most one access per cycle and generates per-requester stall signals. It tracks in-flight accesses so each response returns to its owner, and applies fixed data-first priority with an anti-starvation override for fetch.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, pipelined memory between the fetch port and the
// data port. At most one access is granted per cycle; data wins conflicts
// unless fetch has been denied STARVE_MAX cycles in a row. A shift register
// of in-flight accesses routes each response back to the port that issued it.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_stall,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_stall,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] conflict_cnt
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic        if_grant;
    logic        dm_grant;
    logic        tail_valid;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    // One entry per pipeline stage of the memory; owner 1 = data port.
    logic [MEM_LATENCY-1:0] trk_valid_q, trk_valid_d;
    logic [MEM_LATENCY-1:0] trk_owner_q, trk_owner_d;
    logic [MEM_LATENCY-1:0] trk_we_q, trk_we_d;

    // Grant selection and per-port stalls; reset and hold suppress all grants.
    always_comb begin
        if_grant = 1'b0;
        dm_grant = 1'b0;
        if (reset && !hold) begin
            if (if_req && dm_req) begin
                if (starve_cnt_q == StarveMax) begin
                    if_grant = 1'b1;
                end else begin
                    dm_grant = 1'b1;
                end
            end else begin
                if_grant = if_req;
                dm_grant = dm_req;
            end
        end
        // Gated by reset so every output reads 0 during the reset cycle.
        if_stall = reset & if_req & ~if_grant;
        dm_stall = reset & dm_req & ~dm_grant;
    end

    // Memory command mux; fetch never writes, idle drives all zeros.
    always_comb begin
        mem_en    = if_grant | dm_grant;
        mem_we    = dm_grant & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_grant) begin
            mem_addr = if_addr;
        end else if (dm_grant) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    // Starvation and conflict counter next-state.
    always_comb begin
        starve_cnt_d   = starve_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (!hold) begin
            if (!if_req || if_grant) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q < StarveMax) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
        if (if_req && dm_req && !hold && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // In-flight tracker: push every cycle at stage 0, shift toward the tail.
    always_comb begin
        trk_valid_d    = '0;
        trk_owner_d    = '0;
        trk_we_d       = '0;
        trk_valid_d[0] = mem_en;
        trk_owner_d[0] = dm_grant;
        trk_we_d[0]    = mem_we;
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            trk_valid_d[i] = trk_valid_q[i-1];
            trk_owner_d[i] = trk_owner_q[i-1];
            trk_we_d[i]    = trk_we_q[i-1];
        end
    end

    // Response routing from the tail entry.
    always_comb begin
        tail_valid   = reset & trk_valid_q[MEM_LATENCY-1];
        if_valid     = tail_valid & ~trk_owner_q[MEM_LATENCY-1];
        dm_valid     = tail_valid & trk_owner_q[MEM_LATENCY-1];
        if_rdata     = if_valid ? mem_rdata : '0;
        dm_rdata     = (dm_valid && !trk_we_q[MEM_LATENCY-1]) ? mem_rdata : '0;
        conflict_cnt = reset ? conflict_cnt_q : '0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt_q   <= '0;
            conflict_cnt_q <= '0;
            trk_valid_q    <= '0;
            trk_owner_q    <= '0;
            trk_we_q       <= '0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
            trk_valid_q    <= trk_valid_d;
            trk_owner_q    <= trk_owner_d;
            trk_we_q       <= trk_we_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (latency 1, 2, 3) share the same
// stimulus; a response-schedule model predicts every output each cycle.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;

    logic [2:0]  if_stall, if_valid, dm_stall, dm_valid, mem_en, mem_we;
    logic [31:0] if_rdata [3];
    logic [31:0] dm_rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [15:0] conflict_cnt [3];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(
            .MEM_LATENCY(g + 1),
            .STARVE_MAX ((g == 2) ? 3 : 4)
        ) u_dut (
            .clock       (clock),
            .reset       (reset),
            .hold        (hold),
            .if_req      (if_req),
            .if_addr     (if_addr),
            .if_stall    (if_stall[g]),
            .if_valid    (if_valid[g]),
            .if_rdata    (if_rdata[g]),
            .dm_req      (dm_req),
            .dm_we       (dm_we),
            .dm_addr     (dm_addr),
            .dm_wdata    (dm_wdata),
            .dm_stall    (dm_stall[g]),
            .dm_valid    (dm_valid[g]),
            .dm_rdata    (dm_rdata[g]),
            .mem_en      (mem_en[g]),
            .mem_we      (mem_we[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_rdata   (mem_rdata),
            .conflict_cnt(conflict_cnt[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: counters plus a table of responses keyed by due cycle.
    int lat  [3] = '{1, 2, 3};
    int smax [3] = '{4, 4, 3};
    int starve [3];
    int confl  [3];
    bit sch_v  [3][8];
    bit sch_dm [3][8];
    bit sch_we [3][8];
    int cyc = 0;

    bit          e_gi [3], e_gd [3];
    logic [5:0]  e_flags [3];
    logic [31:0] e_mem_addr [3], e_mem_wdata [3], e_if_rdata [3], e_dm_rdata [3];
    logic [15:0] e_conf [3];

    task automatic model_eval();
        for (int i = 0; i < 3; i++) begin
            int s;
            bit ev_if, ev_dm, en, we;
            s = cyc % 8;
            e_gi[i] = 1'b0;
            e_gd[i] = 1'b0;
            if (reset && !hold) begin
                if (if_req && dm_req) begin
                    e_gi[i] = (starve[i] == smax[i]);
                    e_gd[i] = !e_gi[i];
                end else begin
                    e_gi[i] = if_req;
                    e_gd[i] = dm_req;
                end
            end
            en = e_gi[i] || e_gd[i];
            we = e_gd[i] && dm_we;
            ev_if = reset && sch_v[i][s] && !sch_dm[i][s];
            ev_dm = reset && sch_v[i][s] && sch_dm[i][s];
            e_flags[i] = {reset && if_req && !e_gi[i], reset && dm_req && !e_gd[i],
                          ev_if, ev_dm, en, we};
            e_mem_addr[i]  = e_gi[i] ? if_addr : (e_gd[i] ? dm_addr : 32'h0);
            e_mem_wdata[i] = e_gd[i] ? dm_wdata : 32'h0;
            e_if_rdata[i]  = ev_if ? mem_rdata : 32'h0;
            e_dm_rdata[i]  = (ev_dm && !sch_we[i][s]) ? mem_rdata : 32'h0;
            e_conf[i]      = reset ? 16'(confl[i]) : 16'h0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                starve[i] = 0;
                confl[i]  = 0;
                for (int k = 0; k < 8; k++) sch_v[i][k] = 1'b0;
            end else begin
                if (!hold) begin
                    if (!if_req || e_gi[i]) starve[i] = 0;
                    else if (starve[i] < smax[i]) starve[i]++;
                end
                if (if_req && dm_req && !hold && confl[i] < 65535) confl[i]++;
                sch_v[i][cyc % 8] = 1'b0;
                if (e_gi[i] || e_gd[i]) begin
                    sch_v[i][(cyc + lat[i]) % 8]  = 1'b1;
                    sch_dm[i][(cyc + lat[i]) % 8] = e_gd[i];
                    sch_we[i][(cyc + lat[i]) % 8] = e_gd[i] && dm_we;
                end
            end
        end
        cyc++;
    endtask

    task automatic settle();
        @(negedge clock);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic drive_idle();
        reset = 1'b1; hold = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        settle();
        advance();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0; if_req = 1'b1; dm_req = 1'b1; hold = 1'b0;
        if_addr = 32'h44; dm_addr = 32'h88; dm_wdata = 32'h1234; mem_rdata = 32'hFFFF;
        for (int c = 0; c < 2; c++) begin
            settle();
            for (int i = 0; i < 3; i++) begin
                logic [5:0] of;
                of = {if_stall[i], dm_stall[i], if_valid[i], dm_valid[i], mem_en[i], mem_we[i]};
                n_checks += 3;
                if (of !== 6'h0) begin
                    n_fail++; $display("FAIL reset_flags inst%0d got %b want 000000", i, of);
                end
                if (mem_addr[i] !== 32'h0 || mem_wdata[i] !== 32'h0) begin
                    n_fail++; $display("FAIL reset_mem inst%0d got %h/%h want 0", i,
                                       mem_addr[i], mem_wdata[i]);
                end
                if (conflict_cnt[i] !== 16'h0) begin
                    n_fail++; $display("FAIL reset_conflict inst%0d got %0d want 0", i,
                                       conflict_cnt[i]);
                end
            end
            advance();
        end
        drive_idle();
        settle();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (conflict_cnt[i] !== 16'h0 || if_valid[i] !== 1'b0 || dm_valid[i] !== 1'b0) begin
                n_fail++; $display("FAIL post_reset inst%0d got cnt=%0d iv=%b dv=%b want 0", i,
                                   conflict_cnt[i], if_valid[i], dm_valid[i]);
            end
        end
        advance();
    endtask

    task automatic test_isolated();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        settle();
        n_checks++;
        if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h10 || mem_we[0] !== 1'b0) begin
            n_fail++; $display("FAIL iso_issue got en=%b addr=%h we=%b want 1/10/0",
                               mem_en[0], mem_addr[0], mem_we[0]);
        end
        advance();
        if_req = 1'b0; mem_rdata = 32'h00500093;
        settle();
        n_checks++;
        if (if_valid[0] !== 1'b1 || if_rdata[0] !== 32'h00500093 || dm_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL iso_resp got iv=%b data=%h dv=%b want 1/00500093/0",
                               if_valid[0], if_rdata[0], dm_valid[0]);
        end
        advance();
        mem_rdata = '0;
    endtask

    task automatic test_conflict();
        do_reset();
        if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            dm_addr = 32'h1000 + 32'(k * 4);
            settle();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (k == 4) begin
                    if (mem_addr[i] !== 32'h80 || dm_stall[i] !== 1'b1 || if_stall[i] !== 1'b0)
                    begin
                        n_fail++; $display("FAIL conflict_if_win k%0d inst%0d got addr=%h ds=%b is=%b",
                                           k, i, mem_addr[i], dm_stall[i], if_stall[i]);
                    end
                end else begin
                    if (mem_addr[i] !== dm_addr || if_stall[i] !== 1'b1 || dm_stall[i] !== 1'b0)
                    begin
                        n_fail++; $display("FAIL conflict_dm_win k%0d inst%0d got addr=%h want %h",
                                           k, i, mem_addr[i], dm_addr);
                    end
                end
                if (k == 5) begin
                    n_checks++;
                    if (conflict_cnt[i] !== 16'd5) begin
                        n_fail++; $display("FAIL conflict_cnt inst%0d got %0d want 5", i,
                                           conflict_cnt[i]);
                    end
                end
            end
            advance();
        end
        drive_idle();
    endtask

    task automatic test_write_ack();
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
        settle();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mem_we[i] !== 1'b1 || mem_wdata[i] !== 32'hDEADBEEF || mem_addr[i] !== 32'h200)
            begin
                n_fail++; $display("FAIL wr_issue inst%0d got we=%b wd=%h want 1/DEADBEEF",
                                   i, mem_we[i], mem_wdata[i]);
            end
        end
        advance();
        dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'h12345678;
        for (int k = 1; k <= 3; k++) begin
            settle();
            n_checks++;
            if (dm_valid[k-1] !== 1'b1 || dm_rdata[k-1] !== 32'h0) begin
                n_fail++; $display("FAIL wr_ack inst%0d got dv=%b data=%h want 1/0", k - 1,
                                   dm_valid[k-1], dm_rdata[k-1]);
            end
            advance();
        end
        drive_idle();
    endtask

    task automatic test_ordering();
        logic [31:0] d [3];
        d[0] = 32'hA0A0A0A0; d[1] = 32'hB1B1B1B1; d[2] = 32'hC2C2C2C2;
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        settle(); advance();
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        settle(); advance();
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h104;
        settle(); advance();
        if_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rdata = d[k];
            settle();
            n_checks++;
            if (k == 1) begin
                if (dm_valid[2] !== 1'b1 || dm_rdata[2] !== d[k] || if_valid[2] !== 1'b0) begin
                    n_fail++; $display("FAIL order_dm k%0d got dv=%b data=%h want 1/%h", k,
                                       dm_valid[2], dm_rdata[2], d[k]);
                end
            end else begin
                if (if_valid[2] !== 1'b1 || if_rdata[2] !== d[k] || dm_valid[2] !== 1'b0) begin
                    n_fail++; $display("FAIL order_if k%0d got iv=%b data=%h want 1/%h", k,
                                       if_valid[2], if_rdata[2], d[k]);
                end
            end
            advance();
        end
        drive_idle();
    endtask

    task automatic test_hold();
        do_reset();
        if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b1; dm_addr = 32'h600;
        for (int c = 0; c < 2; c++) begin settle(); advance(); end
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (mem_en[i] !== 1'b0 || if_stall[i] !== 1'b1 || dm_stall[i] !== 1'b1 ||
                    conflict_cnt[i] !== 16'd2) begin
                    n_fail++; $display("FAIL hold inst%0d got en=%b is=%b ds=%b cnt=%0d", i,
                                       mem_en[i], if_stall[i], dm_stall[i], conflict_cnt[i]);
                end
            end
            advance();
        end
        hold = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_checks++;
            if (c < 2) begin
                if (mem_addr[0] !== 32'h600 || if_stall[0] !== 1'b1) begin
                    n_fail++; $display("FAIL hold_release_dm c%0d got addr=%h want 600", c,
                                       mem_addr[0]);
                end
            end else begin
                if (mem_addr[0] !== 32'h500 || dm_stall[0] !== 1'b1 ||
                    conflict_cnt[0] !== 16'd4) begin
                    n_fail++; $display("FAIL hold_starve_kept got addr=%h cnt=%0d want 500/4",
                                       mem_addr[0], conflict_cnt[0]);
                end
            end
            advance();
        end
        drive_idle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_addr = 32'h44;
        settle(); advance();
        dm_req = 1'b0;
        settle(); advance();
        reset = 1'b0; if_req = 1'b1; dm_req = 1'b1; mem_rdata = 32'hFFFF0000;
        settle();
        for (int i = 0; i < 3; i++) begin
            logic [5:0] of;
            of = {if_stall[i], dm_stall[i], if_valid[i], dm_valid[i], mem_en[i], mem_we[i]};
            n_checks++;
            if (of !== 6'h0 || if_rdata[i] !== 32'h0 || dm_rdata[i] !== 32'h0 ||
                conflict_cnt[i] !== 16'h0) begin
                n_fail++; $display("FAIL midflight_reset inst%0d got flags=%b cnt=%0d", i, of,
                                   conflict_cnt[i]);
            end
        end
        advance();
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        settle();
        n_checks++;
        if (if_valid[1] !== 1'b0 || conflict_cnt[1] !== 16'h0 || if_rdata[1] !== 32'h0) begin
            n_fail++; $display("FAIL midflight_discard got iv=%b cnt=%0d want 0/0", if_valid[1],
                               conflict_cnt[1]);
        end
        advance();
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            settle();
            for (int i = 0; i < 3; i++) begin
                logic [5:0] of;
                of = {if_stall[i], dm_stall[i], if_valid[i], dm_valid[i], mem_en[i], mem_we[i]};
                n_checks += 6;
                if (of !== e_flags[i]) begin
                    n_fail++; $display("FAIL rnd_flags c%0d inst%0d got %b want %b", c, i, of,
                                       e_flags[i]);
                end
                if (mem_addr[i] !== e_mem_addr[i]) begin
                    n_fail++; $display("FAIL rnd_addr c%0d inst%0d got %h want %h", c, i,
                                       mem_addr[i], e_mem_addr[i]);
                end
                if (mem_wdata[i] !== e_mem_wdata[i]) begin
                    n_fail++; $display("FAIL rnd_wdata c%0d inst%0d got %h want %h", c, i,
                                       mem_wdata[i], e_mem_wdata[i]);
                end
                if (if_rdata[i] !== e_if_rdata[i]) begin
                    n_fail++; $display("FAIL rnd_if_rdata c%0d inst%0d got %h want %h", c, i,
                                       if_rdata[i], e_if_rdata[i]);
                end
                if (dm_rdata[i] !== e_dm_rdata[i]) begin
                    n_fail++; $display("FAIL rnd_dm_rdata c%0d inst%0d got %h want %h", c, i,
                                       dm_rdata[i], e_dm_rdata[i]);
                end
                if (conflict_cnt[i] !== e_conf[i]) begin
                    n_fail++; $display("FAIL rnd_conflict c%0d inst%0d got %0d want %0d", c, i,
                                       conflict_cnt[i], e_conf[i]);
                end
            end
            advance();
            // Requests stay stable until instance 0 accepts, with rare withdrawal.
            if (!if_req || e_gi[0] || ($urandom % 16) == 0) begin
                if_req  = ($urandom % 4) != 0;
                if_addr = $urandom;
            end
            if (!dm_req || e_gd[0] || ($urandom % 16) == 0) begin
                dm_req   = ($urandom % 3) != 0;
                dm_we    = $urandom % 2;
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            hold      = ($urandom % 8) == 0;
            reset     = ($urandom % 150) != 0;
            mem_rdata = $urandom;
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_isolated();
        test_conflict();
        test_write_ack();
        test_ordering();
        test_hold();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
